// File: rtl/refill_burst_collector.sv
// Cache-refill front end: turns a line miss into one AXI INCR read burst,
// packs the returned beats into a cache line and strobes it into the return buffer.
module refill_burst_collector #(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [BEAT_WIDTH-1:0] r_data,
  input  logic                  r_last,
  input  logic [1:0]            r_resp,
  output logic                  line_we,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  line_err,
  output logic [2:0]            dbg_state
);

  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_RECV  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic [LINE_WIDTH-1:0]   line_data_q, line_data_d;
  logic                    line_err_q, line_err_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid outputs here are pure functions of the state register.
  assign req_ready = (state_q == S_IDLE);
  assign ar_valid  = (state_q == S_AR);
  assign r_ready   = (state_q == S_RECV) || (state_q == S_DRAIN);
  assign line_we   = (state_q == S_DONE);

  assign ar_addr   = ar_addr_q;
  assign ar_len    = 8'(BEATS - 1);
  assign ar_size   = 3'($clog2(BEAT_WIDTH / 8));
  assign ar_burst  = 2'b01;
  assign line_data = line_data_q;
  assign line_err  = line_err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    ar_addr_d   = ar_addr_q;
    line_data_d = line_data_q;
    line_err_d  = line_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ar_addr_d  = req_addr & ADDR_MASK;
          line_err_d = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (ar_ready) state_d = S_RECV;
      end
      S_RECV: begin
        if (r_valid) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) line_data_d[b*BEAT_WIDTH +: BEAT_WIDTH] = r_data;
          end
          if (r_resp != 2'b00) line_err_d = 1'b1;
          if (r_last) begin
            // Short burst leaves the unfilled slots holding the previous line's data.
            if (beat_cnt_q != LAST_CNT) line_err_d = 1'b1;
            state_d = S_DONE;
          end else if (beat_cnt_q == LAST_CNT) begin
            line_err_d = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_valid && r_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      ar_addr_q   <= '0;
      line_data_q <= '0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ar_addr_q   <= ar_addr_d;
      line_data_q <= line_data_d;
      line_err_q  <= line_err_d;
    end
  end

endmodule
